// File: rtl/seq_mult_unit.sv
// seq_mult_unit - sequential multiplier built from repeated addition.
//
// The larger operand is added to the product min(a,b) times, so the loop
// length is bounded by the smaller operand.  A zero operand skips the loop.
//
// Optional build macro: SEQ_MULT_SIGNED_EN
//   Defined   : a/b are two's complement.  The loop runs on the magnitudes
//               and the sign is applied on the last addition.
//   Undefined : a/b are unsigned.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   abort    in   synchronous cancel of an operation in progress
//   a, b     in   operands [WIDTH-1:0], sampled on the accepting edge
//   busy     out  high while in ADD or DONE
//   done     out  one-cycle pulse in DONE
//   product  out  [2*WIDTH-1:0] result, held until the next accept or abort
module seq_mult_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t               r_state, w_next;
   logic [WIDTH-1:0]     r_acc_op, r_cnt;
   logic [2*WIDTH-1:0]   r_product;
   logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_min, w_max;
   logic [2*WIDTH-1:0]   w_sum, w_final;
   logic                 w_accept, w_last;

`ifdef SEQ_MULT_SIGNED_EN
   logic r_neg;
   logic w_neg;

   // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct as unsigned.
   assign w_a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
   assign w_b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
   assign w_neg   = a[WIDTH-1] ^ b[WIDTH-1];
   assign w_final = r_neg ? (~w_sum + (2*WIDTH)'(1)) : w_sum;
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
   assign w_final = w_sum;
`endif

   assign w_min    = (w_a_mag < w_b_mag) ? w_a_mag : w_b_mag;
   assign w_max    = (w_a_mag < w_b_mag) ? w_b_mag : w_a_mag;
   assign w_sum    = r_product + {{WIDTH{1'b0}}, r_acc_op};
   assign w_accept = (r_state == S_IDLE) && start && !abort;
   assign w_last   = (r_cnt == WIDTH'(1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (w_min == '0) ? S_DONE : S_ADD;
         S_ADD: begin
            if (abort)       w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_op  <= '0;
         r_cnt     <= '0;
         r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         r_neg     <= 1'b0;
`endif
      end else if (abort && (r_state != S_IDLE)) begin
         r_acc_op  <= '0;
         r_cnt     <= '0;
         r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         r_neg     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_acc_op  <= w_max;
               r_cnt     <= w_min;
               r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
               r_neg     <= w_neg;
`endif
            end
            S_ADD: begin
               r_cnt     <= r_cnt - WIDTH'(1);
               // sign (if any) is folded in on the final addition only
               r_product <= w_last ? w_final : w_sum;
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state == S_ADD) || (r_state == S_DONE);
   assign done    = (r_state == S_DONE);
   assign product = r_product;

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;
   localparam int W = 8;

   logic           clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [W-1:0]   a = '0, b = '0;
   logic           busy, done;
   logic [2*W-1:0] product;

   int checks = 0, errors = 0, cyc = 0;

   typedef struct { logic [15:0] prod; int lat; } exp_t;
   exp_t exp_q[$];

   seq_mult_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .a(a), .b(b), .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Push the expected result, then present start until the DUT takes it.
   // Returns in cycle 1 after the accepting edge.
   task automatic issue(input logic [7:0] ia, input logic [7:0] ib);
      exp_t e;
      int   ma, mb;
      bit   acc;
`ifdef SEQ_MULT_SIGNED_EN
      ma = int'($signed(ia)); if (ma < 0) ma = -ma;
      mb = int'($signed(ib)); if (mb < 0) mb = -mb;
      e.prod = 16'(int'($signed(ia)) * int'($signed(ib)));
`else
      ma = int'(ia);
      mb = int'(ib);
      e.prod = 16'(ma * mb);
`endif
      e.lat = ((ma < mb) ? ma : mb) + 1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib;
      acc = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) begin acc = 1'b1; break; end
      end
      start = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept a=%0d b=%0d: busy never rose, required busy=1", ia, ib);
      end
   endtask

   task automatic wait_done(output logic [15:0] p, output int lat, output bit ok);
      ok = 1'b0; lat = 1; p = 'x;
      for (int t = 0; t < 600; t++) begin
         if (done === 1'b1) begin ok = 1'b1; p = product; break; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      #12;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (product !== 16'h0) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      exp_t e; logic [15:0] p; int lat; bit ok;
      issue(8'd5, 8'd3);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
      wait_done(p, lat, ok);
      e = exp_q.pop_front();
      checks += 2;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL basic_lat got %0d (seen=%0b) want %0d", lat, ok, e.lat); end
      if (p !== e.prod) begin errors++; $display("FAIL basic_prod got %h want %h", p, e.prod); end
      @(posedge clk); #1;
      checks += 2;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b done=%b want 0/0", busy, done); end
      if (product !== e.prod) begin errors++; $display("FAIL basic_hold got %h want %h", product, e.prod); end
   endtask

   task automatic test_large();
      exp_t e; logic [15:0] p; int lat; bit ok;
      logic [7:0] ta [2] = '{8'd200, 8'd255};
      logic [7:0] tb [2] = '{8'd255, 8'd255};
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i]);
         wait_done(p, lat, ok);
         e = exp_q.pop_front();
         checks += 2;
         if (!ok || lat !== e.lat) begin errors++; $display("FAIL large%0d_lat got %0d want %0d", i, lat, e.lat); end
         if (p !== e.prod) begin errors++; $display("FAIL large%0d_prod got %h want %h", i, p, e.prod); end
      end
   endtask

   task automatic test_zero();
      exp_t e; logic [15:0] p; int lat; bit ok;
      logic [7:0] ta [2] = '{8'd0, 8'd9};
      logic [7:0] tb [2] = '{8'd77, 8'd0};
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i]);
         wait_done(p, lat, ok);
         e = exp_q.pop_front();
         checks += 3;
         if (!ok || lat !== 1) begin errors++; $display("FAIL zero%0d_lat got %0d want 1", i, lat); end
         if (p !== 16'h0) begin errors++; $display("FAIL zero%0d_prod got %h want %h", i, p, e.prod); end
         @(posedge clk); #1;
         if (busy !== 1'b0) begin errors++; $display("FAIL zero%0d_busy1 got %b want 0", i, busy); end
      end
   endtask

   task automatic test_abort();
      exp_t e; logic [15:0] p; int lat; bit ok; bit seen;
      issue(8'd10, 8'd10);
      e = exp_q.pop_front();      // aborted, never completes
      start = 1'b1; a = 8'd0; b = 8'd0;   // held start during ADD must be ignored
      @(posedge clk); #1;
      @(posedge clk); #1;         // 3rd ADD cycle
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_pre got busy=%b done=%b want 1/0", busy, done); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; start = 1'b0;
      checks += 2;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b want 0/0", busy, done); end
      if (product !== 16'h0) begin errors++; $display("FAIL abort_prod got %h want 0000", product); end
      seen = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL abort_quiet got activity=1 want 0"); end
      issue(8'd2, 8'd3);
      wait_done(p, lat, ok);
      e = exp_q.pop_front();
      checks += 2;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL abort_next_lat got %0d want %0d", lat, e.lat); end
      if (p !== e.prod) begin errors++; $display("FAIL abort_next_prod got %h want %h", p, e.prod); end
   endtask

   task automatic test_async_reset();
      exp_t e; logic [15:0] p; int lat; bit ok; bit seen;
      issue(8'd10, 8'd10);
      e = exp_q.pop_front();      // discarded by reset
      @(posedge clk); #1;
      @(posedge clk); #4;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", done); end
      if (product !== 16'h0) begin errors++; $display("FAIL areset_prod got %h want 0000", product); end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL areset_quiet got activity=1 want 0"); end
      issue(8'd4, 8'd4);
      wait_done(p, lat, ok);
      e = exp_q.pop_front();
      checks += 2;
      if (!ok || lat !== e.lat) begin errors++; $display("FAIL areset_next_lat got %0d want %0d", lat, e.lat); end
      if (p !== e.prod) begin errors++; $display("FAIL areset_next_prod got %h want %h", p, e.prod); end
   endtask

   task automatic test_back_to_back();
      exp_t e; logic [15:0] p; int lat; bit ok; int d1, d2;
      issue(8'd3, 8'd4);
      wait_done(p, lat, ok);
      d1 = cyc;
      e = exp_q.pop_front();
      checks++;
      if (!ok || p !== e.prod) begin errors++; $display("FAIL b2b0_prod got %h want %h", p, e.prod); end
      issue(8'd6, 8'd2);          // requested during DONE; taken in the IDLE cycle
      wait_done(p, lat, ok);
      d2 = cyc;
      e = exp_q.pop_front();
      checks += 2;
      if (!ok || p !== e.prod) begin errors++; $display("FAIL b2b1_prod got %h want %h", p, e.prod); end
      if (d2 - d1 !== 4) begin errors++; $display("FAIL b2b_gap got %0d want 4", d2 - d1); end
   endtask

`ifdef SEQ_MULT_SIGNED_EN
   task automatic test_signed();
      exp_t e; logic [15:0] p; int lat; bit ok;
      logic [7:0]  ta [3] = '{8'hFD, 8'h80, 8'h80};
      logic [7:0]  tb [3] = '{8'h07, 8'h80, 8'h01};
      logic [15:0] tp [3] = '{16'hFFEB, 16'h4000, 16'hFF80};
      for (int i = 0; i < 3; i++) begin
         issue(ta[i], tb[i]);
         wait_done(p, lat, ok);
         e = exp_q.pop_front();
         checks += 2;
         if (!ok || lat !== e.lat) begin errors++; $display("FAIL signed%0d_lat got %0d want %0d", i, lat, e.lat); end
         if (p !== tp[i]) begin errors++; $display("FAIL signed%0d_prod got %h want %h", i, p, tp[i]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_large();
      test_zero();
      test_abort();
      test_async_reset();
      test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
      test_signed();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
